// File: rtl/raymarch_pkg.sv
// Shared types and defaults for the raymarcher frame scheduler and its scan counter.
package raymarch_pkg;

  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/raymarch_scheduler_pixel_scan_counter.sv
// Raster-order x/y/linear-address counter; the address increments alongside x/y so no multiply is needed.
module pixel_scan_counter
  import raymarch_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                              clk_pixel_in,
  input  logic                              rst_in,
  input  logic                              clear_in,
  input  logic                              advance_in,
  output logic [$clog2(WIDTH)-1:0]          x_out,
  output logic [$clog2(HEIGHT)-1:0]         y_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
  output logic                              last_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_q, last_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_in || (advance_in && last_q)) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (advance_in) begin
      addr_d = addr_q + 1'b1;
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Flag describes the position being loaded, so it is valid together with it.
    last_d = (x_d == X_MAX) && (y_d == Y_MAX);
  end

  always_ff @(posedge clk_pixel_in) begin
    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    if (rst_in) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      last_q <= (WIDTH == 1) && (HEIGHT == 1);
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign x_out    = x_q;
  assign y_out    = y_q;
  assign addr_out = addr_q;
  assign last_out = last_q;

endmodule

// File: rtl/raymarch_scheduler.sv
// Frame scheduler: walks the raymarcher across the frame, forwards finished pixels to the framebuffer
// and reports per-frame completion and RUN-cycle statistics.
module raymarch_scheduler
  import raymarch_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int CONTINUOUS = 0
) (
  input  logic                              clk_pixel_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  output logic                              rm_rst_out,
  output logic [$clog2(WIDTH)-1:0]          curr_x,
  output logic [$clog2(HEIGHT)-1:0]         curr_y,
  input  logic [7:0]                        red_in,
  input  logic [7:0]                        green_in,
  input  logic [7:0]                        blue_in,
  input  logic                              pixel_done_in,
  output logic                              fb_we_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr_out,
  output logic [23:0]                       fb_data_out,
  output logic                              busy_out,
  output logic                              frame_done_out,
  output logic [15:0]                       frame_count_out,
  output logic [31:0]                       frame_cycles_out
);

  localparam int AW = $clog2(WIDTH * HEIGHT);

  state_e        state_q, state_d;
  logic          rm_rst_q, rm_rst_d;
  logic          busy_q, busy_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  rgb_t          fb_data_q, fb_data_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [31:0]   frame_cycles_q, frame_cycles_d;
  logic [31:0]   cyc_q, cyc_d;

  logic [AW-1:0] scan_addr;
  logic          scan_last;
  logic          scan_advance;
  rgb_t          pix_in;

  assign pix_in       = '{r: red_in, g: green_in, b: blue_in};
  assign scan_advance = (state_q == ST_RUN) && pixel_done_in;

  pixel_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .clear_in     (state_q != ST_RUN),
    .advance_in   (scan_advance),
    .x_out        (curr_x),
    .y_out        (curr_y),
    .addr_out     (scan_addr),
    .last_out     (scan_last)
  );

  always_comb begin
    state_d        = state_q;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_data_d      = fb_data_q;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count_q;
    frame_cycles_d = frame_cycles_q;
    cyc_d          = cyc_q;
    unique case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (start_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        cyc_d = sat_inc32(cyc_q);
        if (pixel_done_in) begin
          fb_we_d   = 1'b1;
          fb_addr_d = scan_addr;
          fb_data_d = pix_in;
          if (scan_last) begin
            // Statistics are loaded on entry so they are visible alongside frame_done_out.
            state_d        = ST_DONE;
            frame_done_d   = 1'b1;
            frame_count_d  = frame_count_q + 16'd1;
            frame_cycles_d = cyc_d;
          end
        end
      end
      ST_DONE: begin
        cyc_d   = '0;
        state_d = ((CONTINUOUS != 0) || start_in) ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rm_rst_d = (state_d != ST_RUN);
    busy_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      rm_rst_q       <= 1'b1;
      busy_q         <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_data_q      <= '0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= '0;
      frame_cycles_q <= '0;
      cyc_q          <= '0;
    end else begin
      state_q        <= state_d;
      rm_rst_q       <= rm_rst_d;
      busy_q         <= busy_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_q      <= fb_data_d;
      frame_done_q   <= frame_done_d;
      frame_count_q  <= frame_count_d;
      frame_cycles_q <= frame_cycles_d;
      cyc_q          <= cyc_d;
    end
  end

  assign rm_rst_out       = rm_rst_q;
  assign busy_out         = busy_q;
  assign fb_we_out        = fb_we_q;
  assign fb_addr_out      = fb_addr_q;
  assign fb_data_out      = fb_data_q;
  assign frame_done_out   = frame_done_q;
  assign frame_count_out  = frame_count_q;
  assign frame_cycles_out = frame_cycles_q;

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Self-checking bench for raymarch_scheduler on a 4x3 frame; framebuffer writes go through a scoreboard.
module tb_raymarch_scheduler;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  typedef struct {
    logic [3:0]  addr;
    logic [23:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pd, rst_c, start_c;
  logic [7:0] r, g, b;

  logic        rm_rst, fb_we, busy, fdone;
  logic [1:0]  cx, cy;
  logic [3:0]  fb_addr;
  logic [23:0] fb_data;
  logic [15:0] fcount;
  logic [31:0] fcyc;

  logic        rm_rst_c, fb_we_c, busy_c, fdone_c;
  logic [1:0]  cx_c, cy_c;
  logic [3:0]  fb_addr_c;
  logic [23:0] fb_data_c;
  logic [15:0] fcount_c;
  logic [31:0] fcyc_c;

  raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .CONTINUOUS(0)) dut (
    .clk_pixel_in (clk), .rst_in (rst), .start_in (start), .rm_rst_out (rm_rst),
    .curr_x (cx), .curr_y (cy), .red_in (r), .green_in (g), .blue_in (b),
    .pixel_done_in (pd), .fb_we_out (fb_we), .fb_addr_out (fb_addr), .fb_data_out (fb_data),
    .busy_out (busy), .frame_done_out (fdone), .frame_count_out (fcount),
    .frame_cycles_out (fcyc)
  );

  raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .CONTINUOUS(1)) dut_c (
    .clk_pixel_in (clk), .rst_in (rst_c), .start_in (start_c), .rm_rst_out (rm_rst_c),
    .curr_x (cx_c), .curr_y (cy_c), .red_in (r), .green_in (g), .blue_in (b),
    .pixel_done_in (pd), .fb_we_out (fb_we_c), .fb_addr_out (fb_addr_c), .fb_data_out (fb_data_c),
    .busy_out (busy_c), .frame_done_out (fdone_c), .frame_count_out (fcount_c),
    .frame_cycles_out (fcyc_c)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  frames_seen = 0;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor for the CONTINUOUS=0 instance, sampled mid-cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t e;
    if (fb_we) begin
      check("we_back_to_back", 32'(prev_we), 0);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(e.addr));
        check("fb_data", 32'(fb_data), 32'(e.data));
      end
    end
    prev_we = fb_we;
    if (fdone) frames_seen++;
  end

  // One frame with pixel_done on every 4th RUN cycle; optional mid-RUN start pulse or reset abort.
  task automatic run_frame(input bit use_c, input int glitch_px, input int abort_px);
    for (int i = 0; i < NPIX; i++) begin
      pd = 1'b0;
      for (int w = 0; w < 3; w++) begin
        start = (w == 0) && (i == glitch_px);
        tick();
      end
      start = 1'b0;
      pd = 1'b1;
      r = 8'(i); g = 8'(i); b = 8'(i);
      if (i == abort_px) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pd = 1'b0;
        return;
      end
      if (!use_c) exp_q.push_back('{addr: 4'(i), data: {8'(i), 8'(i), 8'(i)}});
      tick();
      pd = 1'b0;
      check("we_next", 32'(use_c ? fb_we_c : fb_we), 1);
      check("addr_next", 32'(use_c ? fb_addr_c : fb_addr), 32'(i));
      check("curr_x", 32'(use_c ? cx_c : cx), (i == NPIX - 1) ? 0 : 32'((i + 1) % W));
      check("curr_y", 32'(use_c ? cy_c : cy), (i == NPIX - 1) ? 0 : 32'((i + 1) / W));
      check("rm_rst_run", 32'(use_c ? rm_rst_c : rm_rst), (i == NPIX - 1) ? 1 : 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rm_rst"}, 32'(rm_rst), 1);
    check({tag, "_cx"}, 32'(cx), 0);
    check({tag, "_cy"}, 32'(cy), 0);
    check({tag, "_we"}, 32'(fb_we), 0);
    check({tag, "_addr"}, 32'(fb_addr), 0);
    check({tag, "_data"}, 32'(fb_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_fdone"}, 32'(fdone), 0);
    check({tag, "_fcount"}, 32'(fcount), 0);
    check({tag, "_fcyc"}, fcyc, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_c = 1'b1; start = 1'b0; start_c = 1'b0; pd = 1'b0;
    r = '0; g = '0; b = '0;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check("idle_rm_rst", 32'(rm_rst), 1);

    // Full frame, including the row wrap after (3,0).
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 1);
    check("run_rm_rst", 32'(rm_rst), 0);
    run_frame(1'b0, -1, -1);
    check("done_pulse", 32'(fdone), 1);
    check("done_busy", 32'(busy), 0);
    tick();
    check("done_single", 32'(fdone), 0);
    check("frame_count", 32'(fcount), 1);
    check("frame_cycles", fcyc, 48);
    check("idle_after_done", 32'(rm_rst), 1);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("frames_seen", 32'(frames_seen), 1);

    // pixel_done while IDLE must not write or move the coordinates.
    pd = 1'b1; tick(); pd = 1'b0; tick(); pd = 1'b1; tick(); pd = 1'b0;
    check("idle_pd_we", 32'(fb_we), 0);
    check("idle_pd_cx", 32'(cx), 0);

    // Abort with rst_in on the pixel after pixel 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(1'b0, -1, 6);
    check_reset_state("abort");
    check("abort_queue", 32'(exp_q.size()), 0);
    for (int k = 0; k < 4; k++) begin
      pd = (k % 2 == 0);
      tick();
    end
    pd = 1'b0;
    check("abort_no_we", 32'(fb_we), 0);

    // Start pulse during RUN is ignored: same result as the first frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(1'b0, 5, -1);
    check("glitch_done", 32'(fdone), 1);
    tick();
    check("glitch_count", 32'(fcount), 1);
    check("glitch_cycles", fcyc, 48);
    check("glitch_queue", 32'(exp_q.size()), 0);
    check("glitch_frames_seen", 32'(frames_seen), 2);

    // CONTINUOUS instance: back-to-back frames with a single reset cycle in between.
    rst_c = 1'b0;
    tick();
    check("c_idle_rm_rst", 32'(rm_rst_c), 1);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    run_frame(1'b1, -1, -1);
    check("c_done1", 32'(fdone_c), 1);
    check("c_gap_rm_rst", 32'(rm_rst_c), 1);
    tick();
    check("c_restart_rm_rst", 32'(rm_rst_c), 0);
    check("c_restart_busy", 32'(busy_c), 1);
    check("c_restart_cx", 32'(cx_c), 0);
    check("c_restart_cy", 32'(cy_c), 0);
    check("c_count1", 32'(fcount_c), 1);
    run_frame(1'b1, -1, -1);
    check("c_done2", 32'(fdone_c), 1);
    tick();
    check("c_count2", 32'(fcount_c), 2);
    check("c_cycles2", fcyc_c, 48);
    check("c_rerun", 32'(busy_c), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
